// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage
//   Decode stage with valid/ready handshake and an ID/EX pipeline register.
//   Splits the instruction, generates control, resolves jumps early, and
//   interlocks load-use and multiply-use hazards with an internal scoreboard.
//
// Ports
//   clk, reset (async, active-low)
//   in_valid/in_ready, pc, instruction         : fetch side
//   ext_stall, flush                            : pipeline control
//   src_reg1/src_reg2                           : comb. register-file read addresses
//   hazard, is_jump, jump_addr                  : comb. interlock / early jump
//   out_valid, out_pc, mimmediat, out_addr_reg1/2, dest_reg, op_code,
//   funct_code, shamt, regwrite, memtoreg, memread, memwrite, byteword,
//   alusrc, branch, is_mult                     : registered ID/EX contents
module decode_hazard_stage #(
  parameter int ADDR_W           = 32,
  parameter int REG_ADDR_W       = 5,
  parameter int MUL_LATENCY      = 4,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     pc,
  input  logic [31:0]           instruction,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] src_reg1,
  output logic [REG_ADDR_W-1:0] src_reg2,
  output logic                  hazard,
  output logic                  is_jump,
  output logic [ADDR_W-1:0]     jump_addr,
  output logic                  out_valid,
  output logic [ADDR_W-1:0]     out_pc,
  output logic [ADDR_W-1:0]     mimmediat,
  output logic [REG_ADDR_W-1:0] out_addr_reg1,
  output logic [REG_ADDR_W-1:0] out_addr_reg2,
  output logic [REG_ADDR_W-1:0] dest_reg,
  output logic [5:0]            op_code,
  output logic [5:0]            funct_code,
  output logic [4:0]            shamt,
  output logic                  regwrite,
  output logic                  memtoreg,
  output logic                  memread,
  output logic                  memwrite,
  output logic                  byteword,
  output logic                  alusrc,
  output logic                  branch,
  output logic                  is_mult
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LDB   = 6'h20;
  localparam logic [5:0] OP_LDW   = 6'h23;
  localparam logic [5:0] OP_STB   = 6'h28;
  localparam logic [5:0] OP_STW   = 6'h2B;
  localparam logic [5:0] FN_MUL   = 6'h18;

  // one mul entry per cycle the result is still in flight after ID/EX
  localparam int MUL_N = MUL_LATENCY - 1;
  localparam int LDC_W = (LOAD_USE_BUBBLES > 0) ? $clog2(LOAD_USE_BUBBLES + 1) : 1;

  // field split
  logic [5:0]            w_op, w_fn;
  logic [15:0]           w_imm16;
  logic [REG_ADDR_W-1:0] w_rt, w_rd;

  assign w_op     = instruction[31:26];
  assign w_fn     = instruction[5:0];
  assign w_imm16  = instruction[15:0];
  assign src_reg1 = REG_ADDR_W'(instruction[25:21]);
  assign src_reg2 = REG_ADDR_W'(instruction[20:16]);
  assign w_rt     = src_reg2;
  assign w_rd     = REG_ADDR_W'(instruction[15:11]);

  // opcode class
  logic w_r, w_ldw, w_ldb, w_stw, w_stb, w_beq, w_jmp, w_addi, w_ori, w_lui;
  logic w_ld, w_st, w_iop, w_mul;

  assign w_r    = (w_op == OP_RTYPE);
  assign w_ldw  = (w_op == OP_LDW);
  assign w_ldb  = (w_op == OP_LDB);
  assign w_stw  = (w_op == OP_STW);
  assign w_stb  = (w_op == OP_STB);
  assign w_beq  = (w_op == OP_BEQ);
  assign w_jmp  = (w_op == OP_JUMP);
  assign w_addi = (w_op == OP_ADDI);
  assign w_ori  = (w_op == OP_ORI);
  assign w_lui  = (w_op == OP_LUI);
  assign w_ld   = w_ldw | w_ldb;
  assign w_st   = w_stw | w_stb;
  assign w_iop  = w_addi | w_ori | w_lui;
  assign w_mul  = w_r & (w_fn == FN_MUL);

  // decoded fields / control
  logic [ADDR_W-1:0]     w_imm;
  logic [REG_ADDR_W-1:0] w_dest, w_ar1, w_ar2;
  logic                  w_rw, w_rs1_used, w_rs2_used;

  assign w_imm  = w_ori ? ADDR_W'(w_imm16) :
                  w_lui ? ADDR_W'({w_imm16, 16'h0000}) :
                          {{(ADDR_W-16){w_imm16[15]}}, w_imm16};
  assign w_dest = (w_st | w_beq | w_jmp) ? '0 : (w_ld | w_iop) ? w_rt : w_rd;
  assign w_ar2  = (w_ld | w_iop | w_jmp) ? '0 : w_rt;
  assign w_ar1  = (w_lui | w_jmp) ? '0 : src_reg1;
  assign w_rw   = (w_r | w_ld | w_iop) & (w_dest != '0);

  assign w_rs2_used = w_r | w_st | w_beq;
  assign w_rs1_used = ~(w_lui | w_jmp);

  generate
    if (ADDR_W > 28) begin : g_jaddr_hi
      assign jump_addr = {pc[ADDR_W-1:28], instruction[25:0], 2'b00};
    end else begin : g_jaddr
      assign jump_addr = {instruction[25:0], 2'b00};
    end
  endgenerate

  // scoreboard
  logic [LDC_W-1:0]                  r_ld_cnt;
  logic [REG_ADDR_W-1:0]             r_ld_dst;
  logic [MUL_N-1:0]                  r_mul_vld;
  logic [MUL_N-1:0][REG_ADDR_W-1:0]  r_mul_dst;
  logic [MUL_N-1:0]                  w_mul_vld_sh;
  logic [MUL_N-1:0][REG_ADDR_W-1:0]  w_mul_dst_sh;
  logic                              w_ld_hit, w_mul_hit;

  function automatic logic f_match(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] rs1,
                                   input logic [REG_ADDR_W-1:0] rs2,
                                   input logic u1, input logic u2);
    return (dst != '0) & ((u1 & (rs1 == dst)) | (u2 & (rs2 == dst)));
  endfunction

  // entries age by one; slot 0 is refilled by the caller
  assign w_mul_vld_sh = r_mul_vld << 1;
  assign w_mul_dst_sh = r_mul_dst << REG_ADDR_W;

  assign w_ld_hit = (r_ld_cnt != '0) &
                    f_match(r_ld_dst, src_reg1, src_reg2, w_rs1_used, w_rs2_used);

  always_comb begin
    w_mul_hit = 1'b0;
    for (int i = 0; i < MUL_N; i++)
      if (r_mul_vld[i] & f_match(r_mul_dst[i], src_reg1, src_reg2, w_rs1_used, w_rs2_used))
        w_mul_hit = 1'b1;
  end

  assign hazard   = in_valid & (w_ld_hit | w_mul_hit);
  assign in_ready = ~hazard & ~ext_stall;
  assign is_jump  = in_valid & w_jmp & in_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      mimmediat     <= '0;
      out_addr_reg1 <= '0;
      out_addr_reg2 <= '0;
      dest_reg      <= '0;
      op_code       <= '0;
      funct_code    <= '0;
      shamt         <= '0;
      regwrite      <= 1'b0;
      memtoreg      <= 1'b0;
      memread       <= 1'b0;
      memwrite      <= 1'b0;
      byteword      <= 1'b0;
      alusrc        <= 1'b0;
      branch        <= 1'b0;
      is_mult       <= 1'b0;
      r_ld_cnt      <= '0;
      r_ld_dst      <= '0;
      r_mul_vld     <= '0;
      r_mul_dst     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      regwrite  <= 1'b0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
      branch    <= 1'b0;
      is_mult   <= 1'b0;
      r_ld_cnt  <= '0;
      r_mul_vld <= w_mul_vld_sh;
      r_mul_dst <= w_mul_dst_sh;
    end else if (ext_stall) begin
      // hold everything, scoreboard does not age
    end else if (hazard | ~in_valid) begin
      // bubble: kill control, leave data fields as they were
      out_valid <= 1'b0;
      regwrite  <= 1'b0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
      branch    <= 1'b0;
      is_mult   <= 1'b0;
      if (r_ld_cnt != '0) r_ld_cnt <= r_ld_cnt - LDC_W'(1);
      r_mul_vld <= w_mul_vld_sh;
      r_mul_dst <= w_mul_dst_sh;
    end else begin
      out_valid     <= 1'b1;
      out_pc        <= pc;
      mimmediat     <= w_imm;
      out_addr_reg1 <= w_ar1;
      out_addr_reg2 <= w_ar2;
      dest_reg      <= w_dest;
      op_code       <= w_op;
      funct_code    <= w_fn;
      shamt         <= instruction[10:6];
      regwrite      <= w_rw;
      memtoreg      <= w_ld;
      memread       <= w_ld;
      memwrite      <= w_st;
      byteword      <= w_ldw | w_stw;
      alusrc        <= w_ld | w_st | w_iop;
      branch        <= w_beq;
      is_mult       <= w_mul;
      if (w_ld && (w_dest != '0)) begin
        r_ld_cnt <= LDC_W'(LOAD_USE_BUBBLES);
        r_ld_dst <= w_dest;
      end else if (r_ld_cnt != '0) begin
        r_ld_cnt <= r_ld_cnt - LDC_W'(1);
      end
      r_mul_vld    <= w_mul_vld_sh;
      r_mul_dst    <= w_mul_dst_sh;
      r_mul_vld[0] <= w_mul;
      r_mul_dst[0] <= w_dest;
    end
  end

endmodule

// File: tb/tb_decode_hazard_stage.sv
module tb_decode_hazard_stage;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JUMP = 6'h02, OP_ADDI = 6'h08,
                         OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LDW = 6'h23;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_MUL = 6'h18;

  logic        clk = 1'b0;
  logic        reset, in_valid, ext_stall, flush;
  logic        in_ready, hazard, is_jump, out_valid;
  logic [31:0] pc, instruction, jump_addr, out_pc, mimmediat;
  logic [4:0]  src_reg1, src_reg2, out_addr_reg1, out_addr_reg2, dest_reg, shamt;
  logic [5:0]  op_code, funct_code;
  logic        regwrite, memtoreg, memread, memwrite, byteword, alusrc, branch, is_mult;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_hazard_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .instruction(instruction), .ext_stall(ext_stall), .flush(flush),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .hazard(hazard), .is_jump(is_jump),
    .jump_addr(jump_addr), .out_valid(out_valid), .out_pc(out_pc),
    .mimmediat(mimmediat), .out_addr_reg1(out_addr_reg1), .out_addr_reg2(out_addr_reg2),
    .dest_reg(dest_reg), .op_code(op_code), .funct_code(funct_code), .shamt(shamt),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
    .byteword(byteword), .alusrc(alusrc), .branch(branch), .is_mult(is_mult)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    in_valid = 1'b1; instruction = ins;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; instruction = 32'h0;
    repeat (n) step();
  endtask

  // cycles spent with in_ready low while the current instruction waits
  task automatic count_stalls(output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (in_ready) return;
      n++;
      step();
    end
    n = 99;
  endtask

  task automatic test_reset();
    int n;
    drive(rtype(5'd1, 5'd2, 5'd4, FN_MUL)); step();
    drive(rtype(5'd4, 5'd1, 5'd8, FN_SUB)); #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL rst_pre_hazard got=%b exp=1", hazard); end
    reset = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || dest_reg !== 5'd0 || is_mult !== 1'b0 || regwrite !== 1'b0)
      begin bad++; $display("FAIL rst_outputs got v=%b d=%0d m=%b rw=%b exp all 0", out_valid, dest_reg, is_mult, regwrite); end
    total++; if (in_ready !== 1'b1 || hazard !== 1'b0)
      begin bad++; $display("FAIL rst_ready got rdy=%b hz=%b exp rdy=1 hz=0", in_ready, hazard); end
    total++; if (out_pc !== 32'h0 || mimmediat !== 32'h0 || op_code !== 6'h0 || funct_code !== 6'h0)
      begin bad++; $display("FAIL rst_data got pc=%h imm=%h op=%h fn=%h exp 0", out_pc, mimmediat, op_code, funct_code); end
    #2 reset = 1'b1;
    drive(itype(OP_ADDI, 5'd0, 5'd3, 16'hFFFF));
    count_stalls(n);
    total++; if (n !== 0) begin bad++; $display("FAIL rst_sb_empty got=%0d exp=0", n); end
    step();
    total++; if (dest_reg !== 5'd3 || mimmediat !== 32'hFFFF_FFFF || alusrc !== 1'b1 || regwrite !== 1'b1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL rst_addi got d=%0d imm=%h as=%b rw=%b v=%b exp 3 ffffffff 1 1 1", dest_reg, mimmediat, alusrc, regwrite, out_valid); end
    idle(4);
  endtask

  task automatic test_load_use();
    drive(itype(OP_LDW, 5'd1, 5'd5, 16'd4)); step();
    total++; if (out_valid !== 1'b1 || memread !== 1'b1 || memtoreg !== 1'b1 || byteword !== 1'b1 || dest_reg !== 5'd5 || regwrite !== 1'b1)
      begin bad++; $display("FAIL ld_issue got v=%b mr=%b mtr=%b bw=%b d=%0d rw=%b exp 1 1 1 1 5 1", out_valid, memread, memtoreg, byteword, dest_reg, regwrite); end
    drive(rtype(5'd5, 5'd2, 5'd6, FN_ADD)); #1;
    total++; if (hazard !== 1'b1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL ld_use_hazard got hz=%b rdy=%b exp 1 0", hazard, in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || memread !== 1'b0)
      begin bad++; $display("FAIL ld_use_bubble got v=%b mr=%b exp 0 0", out_valid, memread); end
    #1;
    total++; if (hazard !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL ld_use_release got hz=%b rdy=%b exp 0 1", hazard, in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || dest_reg !== 5'd6 || out_addr_reg1 !== 5'd5 || out_addr_reg2 !== 5'd2 || funct_code !== FN_ADD)
      begin bad++; $display("FAIL ld_use_add got v=%b d=%0d a1=%0d a2=%0d fn=%h exp 1 6 5 2 20", out_valid, dest_reg, out_addr_reg1, out_addr_reg2, funct_code); end
    // independent follower
    drive(itype(OP_LDW, 5'd1, 5'd5, 16'd4)); step();
    drive(rtype(5'd7, 5'd2, 5'd6, FN_ADD)); #1;
    total++; if (hazard !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL ld_indep got hz=%b rdy=%b exp 0 1", hazard, in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_addr_reg1 !== 5'd7 || memread !== 1'b0)
      begin bad++; $display("FAIL ld_indep_issue got v=%b a1=%0d mr=%b exp 1 7 0", out_valid, out_addr_reg1, memread); end
    idle(4);
  endtask

  task automatic test_mul();
    int n;
    drive(rtype(5'd1, 5'd2, 5'd4, FN_MUL)); step();
    total++; if (is_mult !== 1'b1 || dest_reg !== 5'd4 || regwrite !== 1'b1)
      begin bad++; $display("FAIL mul_issue got m=%b d=%0d rw=%b exp 1 4 1", is_mult, dest_reg, regwrite); end
    drive(rtype(5'd4, 5'd1, 5'd8, FN_SUB)); count_stalls(n);
    total++; if (n !== 3) begin bad++; $display("FAIL mul_use_b2b got=%0d exp=3", n); end
    step();
    total++; if (out_valid !== 1'b1 || dest_reg !== 5'd8 || is_mult !== 1'b0)
      begin bad++; $display("FAIL mul_dep_issue got v=%b d=%0d m=%b exp 1 8 0", out_valid, dest_reg, is_mult); end
    idle(4);
    drive(rtype(5'd1, 5'd2, 5'd4, FN_MUL)); step();
    drive(32'h0); step();
    drive(rtype(5'd4, 5'd1, 5'd8, FN_SUB)); count_stalls(n);
    total++; if (n !== 2) begin bad++; $display("FAIL mul_use_gap1 got=%0d exp=2", n); end
    step(); idle(4);
    drive(rtype(5'd1, 5'd2, 5'd0, FN_MUL)); step();
    total++; if (is_mult !== 1'b1 || regwrite !== 1'b0)
      begin bad++; $display("FAIL mul_r0_ctl got m=%b rw=%b exp 1 0", is_mult, regwrite); end
    drive(rtype(5'd0, 5'd1, 5'd8, FN_SUB)); count_stalls(n);
    total++; if (n !== 0) begin bad++; $display("FAIL mul_r0_stall got=%0d exp=0", n); end
    step(); idle(4);
  endtask

  task automatic test_jump();
    pc = 32'h3000_0010;
    drive({OP_JUMP, 26'h000_0040}); flush = 1'b1; #1;
    total++; if (is_jump !== 1'b0) begin bad++; $display("FAIL jump_flush got=%b exp=0", is_jump); end
    flush = 1'b0; #1;
    total++; if (is_jump !== 1'b1 || jump_addr !== 32'h3000_0100)
      begin bad++; $display("FAIL jump_comb got j=%b a=%h exp 1 30000100", is_jump, jump_addr); end
    step();
    total++; if (regwrite !== 1'b0 || dest_reg !== 5'd0 || out_valid !== 1'b1 || out_pc !== 32'h3000_0010 || out_addr_reg1 !== 5'd0)
      begin bad++; $display("FAIL jump_reg got rw=%b d=%0d v=%b pc=%h a1=%0d exp 0 0 1 30000010 0", regwrite, dest_reg, out_valid, out_pc, out_addr_reg1); end
    pc = 32'h0; idle(2);
  endtask

  task automatic test_flush();
    drive(itype(OP_LDW, 5'd1, 5'd5, 16'd4)); step();
    drive(rtype(5'd5, 5'd2, 5'd6, FN_ADD)); flush = 1'b1; #1;
    total++; if (hazard !== 1'b1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL flush_hz got hz=%b rdy=%b exp 1 0", hazard, in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || regwrite !== 1'b0 || memread !== 1'b0)
      begin bad++; $display("FAIL flush_kill got v=%b rw=%b mr=%b exp 0 0 0", out_valid, regwrite, memread); end
    flush = 1'b0; #1;
    total++; if (hazard !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_ldclr got hz=%b rdy=%b exp 0 1", hazard, in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || dest_reg !== 5'd6)
      begin bad++; $display("FAIL flush_add got v=%b d=%0d exp 1 6", out_valid, dest_reg); end
    idle(4);
  endtask

  task automatic test_ext_stall();
    int n;
    bit hold_ok;
    drive(rtype(5'd1, 5'd2, 5'd4, FN_MUL)); step();
    drive(rtype(5'd4, 5'd1, 5'd8, FN_SUB)); ext_stall = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (in_ready !== 1'b0 || hazard !== 1'b1) hold_ok = 1'b0;
      step();
      if (out_valid !== 1'b1 || is_mult !== 1'b1 || dest_reg !== 5'd4 || funct_code !== FN_MUL) hold_ok = 1'b0;
    end
    total++; if (hold_ok !== 1'b1)
      begin bad++; $display("FAIL stall_hold got v=%b m=%b d=%0d fn=%h exp 1 1 4 18", out_valid, is_mult, dest_reg, funct_code); end
    ext_stall = 1'b0; count_stalls(n);
    total++; if (n !== 3) begin bad++; $display("FAIL stall_aging got=%0d exp=3", n); end
    step();
    total++; if (out_valid !== 1'b1 || dest_reg !== 5'd8 || funct_code !== FN_SUB)
      begin bad++; $display("FAIL stall_sub got v=%b d=%0d fn=%h exp 1 8 22", out_valid, dest_reg, funct_code); end
    drive(itype(OP_ORI, 5'd1, 5'd2, 16'h8000)); step();
    total++; if (mimmediat !== 32'h0000_8000 || dest_reg !== 5'd2 || alusrc !== 1'b1 || out_addr_reg2 !== 5'd0)
      begin bad++; $display("FAIL ori_imm got imm=%h d=%0d as=%b a2=%0d exp 00008000 2 1 0", mimmediat, dest_reg, alusrc, out_addr_reg2); end
    drive(itype(OP_LUI, 5'd7, 5'd9, 16'h1234)); step();
    total++; if (mimmediat !== 32'h1234_0000 || dest_reg !== 5'd9 || out_addr_reg1 !== 5'd0)
      begin bad++; $display("FAIL lui_imm got imm=%h d=%0d a1=%0d exp 12340000 9 0", mimmediat, dest_reg, out_addr_reg1); end
    drive(itype(6'h3F, 5'd1, 5'd2, 16'h1800)); step();
    total++; if (out_valid !== 1'b1 || regwrite !== 1'b0 || alusrc !== 1'b0 || memread !== 1'b0 || memwrite !== 1'b0 || branch !== 1'b0)
      begin bad++; $display("FAIL unknown_op got v=%b rw=%b as=%b mr=%b mw=%b br=%b exp 1 0 0 0 0 0", out_valid, regwrite, alusrc, memread, memwrite, branch); end
    // flush beats ext_stall in the same cycle
    ext_stall = 1'b1; flush = 1'b1; step();
    total++; if (out_valid !== 1'b0)
      begin bad++; $display("FAIL flush_over_stall got=%b exp=0", out_valid); end
    ext_stall = 1'b0; flush = 1'b0;
    idle(4);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    pc = 32'h0; instruction = 32'h0;
    step(); step();
    reset = 1'b1;
    step();
    test_reset();
    test_load_use();
    test_mul();
    test_jump();
    test_flush();
    test_ext_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised second-generation DECODE stage with a valid/ready handshake and an ID/EX pipeline register. It splits the instruction into fields, generates control, resolves jumps early, and interlocks load-use and multiply-use hazards with an internal scoreboard. It sits between fetch and EX/MUL, drives the register-file read addresses combinationally, and inserts bubbles instead of relying on an external hazard unit.

## Interface
Parameters:
- ADDR_W, 32, PC / immediate / jump-address width (≥ 28)
- REG_ADDR_W, 5, register address width
- MUL_LATENCY, 4, cycles until a multiply result can be forwarded (≥ 2)
- LOAD_USE_BUBBLES, 1, bubbles after a load whose dest is read next (0 disables)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- in_valid  in  1  fetch presents pc/instruction
- in_ready  out  1  = ~hazard & ~ext_stall; instruction consumed when in_valid & in_ready
- pc  in  ADDR_W  PC of incoming instruction
- instruction  in  32  instruction word
- ext_stall  in  1  downstream stall; ID/EX register and scoreboard hold
- flush  in  1  squash: kill the ID/EX contents and the incoming instruction
- src_reg1 / src_reg2  out  REG_ADDR_W  combinational [25:21] / [20:16] to register file
- hazard  out  1  combinational interlock indicator
- is_jump  out  1  combinational: in_valid & opcode==OP_JUMP & in_ready & ~flush
- jump_addr  out  ADDR_W  {pc[ADDR_W-1:28], instruction[25:0], 2'b00}
- out_valid  out  1  ID/EX register holds a real instruction
- out_pc, mimmediat  out  ADDR_W  registered
- out_addr_reg1, out_addr_reg2, dest_reg  out  REG_ADDR_W  registered
- op_code, funct_code  out  6  registered; shamt  out  5  registered
- regwrite, memtoreg, memread, memwrite, byteword, alusrc, branch, is_mult  out  1  registered

## Operation
- Field split: opcode [31:26], funct [5:0], shamt [10:6]; OP_*/FN_* codes from define.v.
- Immediate: ORI zero-extend; LUI {imm16, 0}; all others sign-extend imm16 to ADDR_W.
- dest_reg: STW/STB/BEQ/JUMP → 0; LDW/LDB/ADDI/ORI/LUI → [20:16]; else [15:11].
- out_addr_reg2: 0 for LDW/LDB/ADDI/ORI/LUI/JUMP, else [20:16]; out_addr_reg1: 0 for LUI/JUMP, else [25:21].
- Control: regwrite = RTYPE|LDx|ADDI|ORI|LUI, forced 0 when dest_reg==0; memtoreg = memread = LDW|LDB; memwrite = STW|STB; byteword = 1 for LDW/STW, 0 for LDB/STB; alusrc = LDx|STx|ADDI|ORI|LUI; branch = BEQ; is_mult = RTYPE & funct==FN_MUL. Unknown opcode: all controls 0, out_valid 1.
- rs2_used = RTYPE|STW|STB|BEQ; rs1_used = all except LUI/JUMP.
- Scoreboard: load tracker (counter ld_cnt, reg ld_dst); mul tracker (MUL_LATENCY-1 entry shift register of {valid, dst}).
- hazard = in_valid & ((ld_cnt≠0 & match(ld_dst)) | any valid mul entry matches); match means (rs1_used & src_reg1==dst) | (rs2_used & src_reg2==dst), dst≠0.
- Per edge, priority order:
  - flush: out_valid, regwrite, memread, memwrite, branch, is_mult ← 0; ld_cnt ← 0; mul entry 0 invalidated; other entries shift.
  - else ext_stall: everything holds.
  - else hazard or ~in_valid: bubble (as flush, data fields hold); ld_cnt decrements if nonzero; mul entries shift.
  - else accept: load all fields, out_valid ← 1; a load with dest≠0 sets ld_cnt ← LOAD_USE_BUBBLES, ld_dst ← dest; a multiply loads entry 0 {1, dest}; otherwise ld_cnt decrements and entry 0 ← invalid.
- Reset: every registered output 0, ld_cnt 0, all mul entries invalid.

## Timing
- Decode latency 1 cycle; src_reg*, hazard, is_jump, jump_addr combinational from the same cycle's instruction.
- Load followed immediately by a dependent: exactly LOAD_USE_BUBBLES bubbles; independent follower: none.
- MUL followed immediately by a dependent: MUL_LATENCY-1 bubbles; a dependent k cycles later gets max(0, MUL_LATENCY-1-k).
- ext_stall freezes scoreboard aging, so bubble counts are in non-stalled cycles.
- flush with ext_stall in the same cycle: flush wins. flush with hazard: flush wins and in_ready still reflects hazard.
- reset mid-operation: outputs clear asynchronously; the first accept after release sees an empty scoreboard.

## Test plan
- Reset: drive instructions, pull reset low mid-stream → all outputs 0 and in_ready=1 immediately; after release, ADDI r3,r0,-1 → next cycle dest_reg=3, mimmediat=32'hFFFFFFFF, alusrc=1, regwrite=1.
- Load-use: LDW r5,4(r1) then ADD r6,r5,r2 → one cycle in_ready=0, hazard=1, out_valid=0 bubble, then ADD issues; the same pair with ADD r6,r7,r2 → no bubble.
- Multiply (MUL_LATENCY=4): MUL r4,r1,r2 then SUB r8,r4,r1 → 3 bubbles; MUL, NOP, SUB r8,r4,r1 → 2 bubbles; MUL writing r0 → no stall.
- Jump: JUMP imm26=0x0000040 at pc=0x3000_0010 → is_jump=1 same cycle, jump_addr=0x3000_0100, registered regwrite=0, dest_reg=0.
- Flush during load-use stall: LDW r5 issued, ADD using r5 stalled, flush asserted → out_valid=0, ld_cnt cleared, ADD accepted the following cycle with no bubble.
- ext_stall: hold 3 cycles with a valid MUL in ID/EX → outputs unchanged, hazard duration extended by 3, and ORI r2,r1,0x8000 after release gives mimmediat=0x0000_8000.
